// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC and instruction-fetch stage feeding decode over a valid/ready handshake.
// Control flow (Br, RET, HLT, sequential) is resolved locally on the accept edge.
module fetch_sequencer #(
   parameter int PC_W = 4,
   parameter int IW = 8,
   parameter logic [IW-1:0] HLT_WORD = 8'hFF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic [PC_W-1:0] pc,
   input  logic [IW-1:0]   instr_in,
   output logic [IW-1:0]   ir,
   output logic            ir_valid,
   input  logic            exec_ready,
   input  logic            br_flag,
   output logic            halted,
   output logic [7:0]      icount
);
   typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;
   state_t state_q;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [IW-1:0] ir_q;
   logic ir_valid_q, halted_q;
   logic [7:0] icount_q;
   logic [3:0] opcode;
   assign opcode = ir_q[IW-1:IW-4];
   // br_flag only matters for Br; RET jumps unconditionally
   always_comb
      pc_d = ((opcode == 4'b1000) && br_flag) || (opcode == 4'b1011) ? ir_q[PC_W-1:0] : pc_q + PC_W'(1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q <= '0;
         ir_q <= '0;
         ir_valid_q <= 1'b0;
         halted_q <= 1'b0;
         icount_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (start) state_q <= FETCH;
            FETCH: begin
               ir_q <= instr_in;
               ir_valid_q <= 1'b1;
               state_q <= ISSUE;
            end
            ISSUE: if (exec_ready) begin
               icount_q <= icount_q + 8'd1;
               ir_valid_q <= 1'b0;
               if (ir_q == HLT_WORD) begin
                  halted_q <= 1'b1;
                  state_q <= HALT;
               end else begin
                  pc_q <= pc_d;
                  state_q <= FETCH;
               end
            end
            default: ;
         endcase
      end
   assign pc = pc_q;
   assign ir = ir_q;
   assign ir_valid = ir_valid_q;
   assign halted = halted_q;
   assign icount = icount_q;
endmodule
